// File: rtl/ones_comp_pkg.sv
// Shared types and constants for the bit-serial ones'-complement ALU.
`timescale 1ns/1ps
package ones_comp_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    WRAP = 2'd2,
    DONE = 2'd3
  } state_t;

  // Bit-index counter width; a floor of one bit keeps the counter legal.
  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, time-shared by the serial ALU.
`timescale 1ns/1ps
module full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Y,
  output logic Cout
);

  assign Y    = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);

endmodule

// File: rtl/ones_comp_serial_alu.sv
// Bit-serial ones'-complement add/subtract with end-around-carry wrap pass.
// Build option: define NORM_NEG_ZERO_EN to write a -0 result to Y as +0.
`timescale 1ns/1ps
module ones_comp_serial_alu
  import ones_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y,
  output logic             neg_zero
);

  localparam int                 IDX_W    = idx_width(WIDTH);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  logic [WIDTH-1:0] r_res;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;

  logic             w_fa_a;
  logic             w_fa_b;
  logic             w_fa_cin;
  logic             w_sum;
  logic             w_cout;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);

  full_adder u_cell (
    .A    (w_fa_a),
    .B    (w_fa_b),
    .Cin  (w_fa_cin),
    .Y    (w_sum),
    .Cout (w_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // The result register shifts LSB-first, so during WRAP bit r_res[0] is
  // always the bit whose index matches r_idx; a full WRAP rotates it back.
  always_comb begin
    w_next   = r_state;
    w_fa_a   = 1'b0;
    w_fa_b   = 1'b0;
    w_fa_cin = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_next = ADD;
      end
      ADD: begin
        w_fa_a   = r_op_a[r_idx];
        w_fa_b   = r_op_b[r_idx];
        w_fa_cin = r_carry;
        if (w_last) w_next = w_cout ? WRAP : DONE;
      end
      WRAP: begin
        w_fa_a   = r_res[0];
        w_fa_cin = r_carry;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_res    <= '0;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Y        <= '0;
      neg_zero <= 1'b0;
    end else begin
      done <= (r_state == DONE);
      busy <= (w_next != IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op_a  <= A;
            r_op_b  <= sub ? ~B : B;
            r_carry <= 1'b0;
            r_idx   <= '0;
          end
        end
        ADD, WRAP: begin
          // On the last ADD bit the carry-out is the around bit, seeding WRAP.
          r_res   <= {w_sum, r_res[WIDTH-1:1]};
          r_carry <= w_cout;
          r_idx   <= w_last ? '0 : r_idx + 1'b1;
        end
        DONE: begin
          neg_zero <= &r_res;
`ifdef NORM_NEG_ZERO_EN
          Y <= (&r_res) ? '0 : r_res;
`else
          Y <= r_res;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ones_comp_serial_alu.sv
// Scoreboard bench for ones_comp_serial_alu against an arithmetic reference model.
`timescale 1ns/1ps
module tb_ones_comp_serial_alu;

  localparam int W = 4;

  typedef struct {
    logic [W-1:0] y;
    logic         nz;
    int           lat;
    int           e0;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] y;
  logic         nz;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ones_comp_serial_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
    .Y        (y),
    .neg_zero (nz)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Integer ones'-complement arithmetic: add, fold any overflow back in once.
  function automatic exp_t model(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t        e;
    int unsigned full;
    int unsigned bb;
    int unsigned sum;
    full = (1 << W) - 1;
    bb   = s ? (full - int'(bv)) : int'(bv);
    sum  = int'(av) + bb;
    e.lat = W + 1;
    if (sum > full) begin
      sum   = sum - (full + 1) + 1;
      e.lat = 2 * W + 1;
    end
    e.nz = (sum == full);
`ifdef NORM_NEG_ZERO_EN
    e.y = e.nz ? '0 : W'(sum);
`else
    e.y = W'(sum);
`endif
    e.e0 = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("Y", 32'(y), 32'(e.y));
        check("neg_zero", 32'(nz), 32'(e.nz));
        check("latency", 32'(cyc - e.e0), 32'(e.lat));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic wait_drain();
    int i;
    i = 0;
    while (sb.size() != 0 && i < 4 * W + 10) begin
      @(negedge clk);
      #1;
      i++;
    end
    if (sb.size() != 0) begin
      check("done_timeout", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic issue(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv, input int hold);
    exp_t e;
    e = model(s, av, bv);
    start = 1'b1;
    sub   = s;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    e.e0 = cyc;
    sb.push_back(e);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      a   = W'($urandom);
      b   = W'($urandom);
      sub = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    sub   = 1'($urandom);
    wait_drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_Y", 32'(y), 32'd0);
    check("reset_neg_zero", 32'(nz), 32'd0);

    issue(1'b0, 4'b0011, 4'b0100, 0);
    issue(1'b1, 4'b0101, 4'b0011, 0);
    issue(1'b0, 4'b0111, 4'b1001, 0);
    issue(1'b1, 4'b0110, 4'b0110, 0);
    issue(1'b0, 4'b0011, 4'b0100, W - 1);
    issue(1'b1, 4'b0011, 4'b0101, 0);

    // Abort an operation in its wrap pass.
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 4'b0101; b = 4'b0011;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("busy_in_wrap", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_Y", 32'(y), 32'd0);
    check("abort_neg_zero", 32'(nz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    #1;
    check("post_abort_done", 32'(done), 32'd0);
    check("post_abort_busy", 32'(busy), 32'd0);

    issue(1'b1, 4'b0101, 4'b0011, 0);

    for (int n = 0; n < 40; n++) begin
      issue(1'($urandom), W'($urandom), W'($urandom), int'($urandom_range(0, W - 1)));
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ones_comp_serial_alu.md
Name: ones_comp_serial_alu

Overview:
Bit-serial ones'-complement add/subtract controller that time-shares a single full_adder cell across all bit positions.
- Pass 1 (ADD): sequences operand bits LSB-first through the cell.
- Pass 2 (WRAP): re-circulates the result to apply the end-around carry, only when pass 1 produces a carry-out.
- Used where area matters more than latency; it is the serial counterpart of the parallel ones'-complement adder.
- Start/busy/done handshake toward the requester.

Parameters:
WIDTH, 4, operand/result width in bits (>=2)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; sampled only in IDLE
sub  input  1  0: Y=A+B, 1: Y=A-B (A plus bitwise-inverted B); sampled with start
A  input  WIDTH  operand A, ones'-complement; sampled with start
B  input  WIDTH  operand B, ones'-complement; sampled with start
busy  output  1  high from the edge after start is accepted until the edge that raises done
done  output  1  one-cycle pulse; Y valid from this cycle onward
Y  output  WIDTH  result register; holds until the next done
neg_zero  output  1  raw result was all ones (-0); updated with Y

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, Y=0, neg_zero=0, bit index=0, carry=0, operand registers=0. Reset during ADD/WRAP aborts; no done pulse follows.
- States: IDLE, ADD, WRAP, DONE.
- IDLE: start=1 at edge e0 latches opA=A and opB=(sub ? ~B : B), clears carry and index, goes to ADD, busy=1.
- ADD: one bit per cycle; cell inputs opA[idx], opB[idx], carry; sum shifts into result shift register; carry<=Cout; idx increments.
  - After bit WIDTH-1 (edge e0+WIDTH), the final carry is the around bit.
  - around=1: go to WRAP with carry=1, idx=0. around=0: go to DONE.
- WRAP: one bit per cycle; cell inputs result[idx], 0, carry. Always runs exactly WIDTH cycles; no early exit, so latency is deterministic. Any carry out of WRAP is discarded.
- DONE: Y<=result, neg_zero<=(result==all ones), done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: done is high in the cycle after edge e0+WIDTH+1 without wrap, or edge e0+2*WIDTH+1 with wrap.
- start while busy or in DONE: ignored; not queued.
- start in the IDLE cycle directly after DONE: accepted normally (back-to-back).
- Width rule: all arithmetic is modulo 2^WIDTH, with the end-around carry applied once.

Optional Feature:
NORM_NEG_ZERO_EN
- Defined: a raw all-ones result is written to Y as all zeros (+0); neg_zero still reports the raw -0.
- Undefined: Y is the raw result, -0 included. neg_zero behaves identically in both builds; latency is unchanged.

Decomposition:
- Package ones_comp_pkg: state enum (IDLE, ADD, WRAP, DONE), default width constant, index width as $clog2(WIDTH).
- Sub-module: exactly one instance of the existing full_adder (A, B, Cin, Y, Cout) as the shared bit cell. Controller, index counter, carry flop and shift registers stay in this module.

Test Plan:
- Reset then idle -> Y=0000, busy=0, done=0, neg_zero=0.
- sub=0, A=0011, B=0100 -> no wrap, Y=0111, neg_zero=0; done after edge e0+5.
- sub=1, A=0101, B=0011 -> 0101+1100 gives around=1, WRAP, Y=0010; done after edge e0+9.
- sub=0, A=0111, B=1001 -> wrap with carry rippling, Y=0001. Then sub=1, A=0011, B=0101 -> Y=1101 (-2), no wrap.
- sub=1, A=B=0110 -> raw 1111, neg_zero=1; Y=1111 without NORM_NEG_ZERO_EN, Y=0000 with it.
- start held high through an op -> exactly one done per accepted start. Assert rst during WRAP -> busy=0, Y=0, no done pulse. New start after reset -> correct result.
